// File: rtl/block_code_pkg.sv
// Shared constants, decoded-word layout and helpers for the block-code
// decision stage that follows the fast Hadamard transform.
package block_code_pkg;

  localparam int COEF_WIDTH      = 10;
  localparam int LOG2_N          = 5;
  localparam int MASK_BITS       = 7;
  localparam int DEC_WIDTH       = 1 + LOG2_N + MASK_BITS;
  localparam int MAX_CODE_LENGTH = 13;

  // Decoded word layout, LSB first: sign, Walsh index, mask index.
  typedef struct packed {
    logic [MASK_BITS-1:0] mask;
    logic [LOG2_N-1:0]    idx;
    logic                 sign;
  } dec_word_t;

  // Keep only the low len bits of a decoded word; higher bits read as zero.
  function automatic logic [DEC_WIDTH-1:0] mask_to_length(
    input logic [DEC_WIDTH-1:0] word,
    input logic [3:0]           len
  );
    logic [DEC_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      if (i < int'(len)) res[i] = word[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/coef_magnitude.sv
// First pipeline stage of the max search: magnitude and sign of the incoming
// coefficient, registered together with its framing side-band.
module coef_magnitude #(
  parameter int W  = 10,
  parameter int IW = 5,
  parameter int MW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  coef,
  input  logic [IW-1:0] idx,
  input  logic [MW-1:0] mask,
  input  logic          first,
  input  logic          eoc,
  input  logic          err,
  input  logic [3:0]    len,
  output logic          s1_valid,
  output logic [W-1:0]  s1_mag,
  output logic          s1_sign,
  output logic [IW-1:0] s1_idx,
  output logic [MW-1:0] s1_mask,
  output logic          s1_first,
  output logic          s1_eoc,
  output logic          s1_err,
  output logic [3:0]    s1_len
);

  // Two's complement negation; the most negative value becomes 2^(W-1)
  // which still fits as an unsigned W-bit magnitude.
  logic [W-1:0] mag;
  assign mag = coef[W-1] ? (~coef + 1'b1) : coef;

  // Register magnitude and side-band; data only moves on valid beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mag   <= '0;
      s1_sign  <= 1'b0;
      s1_idx   <= '0;
      s1_mask  <= '0;
      s1_first <= 1'b0;
      s1_eoc   <= 1'b0;
      s1_err   <= 1'b0;
      s1_len   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag   <= mag;
        s1_sign  <= coef[W-1];
        s1_idx   <= idx;
        s1_mask  <= mask;
        s1_first <= first;
        s1_eoc   <= eoc;
        s1_err   <= err;
        s1_len   <= len;
      end
    end
  end

endmodule

// File: rtl/fht_max_search.sv
// Decision stage after the FHT: finds the largest-magnitude coefficient over
// all mask hypotheses of a codeword and emits {mask, idx, sign} truncated to
// the code length, two cycles after the final beat.
module fht_max_search
  import block_code_pkg::*;
#(
  parameter int COEF_WIDTH = block_code_pkg::COEF_WIDTH,
  parameter int LOG2_N     = block_code_pkg::LOG2_N,
  parameter int MASK_BITS  = block_code_pkg::MASK_BITS,
  parameter int DEC_WIDTH  = block_code_pkg::DEC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [COEF_WIDTH-1:0] coef,
  input  logic                         coef_valid,
  input  logic                         coef_last,
  input  logic                         mask_last,
  input  logic [3:0]                   code_length,
  output logic [DEC_WIDTH-1:0]         dec_bits,
  output logic [COEF_WIDTH-1:0]        best_metric,
  output logic                         dec_valid,
  output logic                         frame_err
);

  logic [LOG2_N-1:0]    coef_idx_reg;
  logic [MASK_BITS-1:0] mask_idx_reg;
  logic                 in_cw_reg;
  logic [3:0]           len_reg;

  logic       first, eoc, len_bad, beat_err;
  logic [3:0] len_cur;

  // Front end: framing checks and per-codeword length capture.
  always_comb begin
    first    = ~in_cw_reg;
    eoc      = coef_last & mask_last;
    len_bad  = (code_length == 4'd0) || (code_length > 4'(MAX_CODE_LENGTH));
    len_cur  = first ? (len_bad ? 4'(MAX_CODE_LENGTH) : code_length) : len_reg;
    beat_err = (coef_last && (coef_idx_reg != '1))
             | (!coef_last && (coef_idx_reg == '1))
             | (coef_last && !mask_last && (mask_idx_reg == '1))
             | (mask_last && !coef_last)
             | (first && len_bad);
  end

  // Coefficient / mask counters and the in-codeword flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_idx_reg <= '0;
      mask_idx_reg <= '0;
      in_cw_reg    <= 1'b0;
      len_reg      <= '0;
    end else if (coef_valid) begin
      in_cw_reg <= ~eoc;
      len_reg   <= len_cur;
      if (coef_last) begin
        coef_idx_reg <= '0;
        mask_idx_reg <= eoc ? '0 : mask_idx_reg + 1'b1;
      end else begin
        coef_idx_reg <= coef_idx_reg + 1'b1;
      end
    end
  end

  logic                  s1_valid, s1_sign, s1_first, s1_eoc, s1_err;
  logic [COEF_WIDTH-1:0] s1_mag;
  logic [LOG2_N-1:0]     s1_idx;
  logic [MASK_BITS-1:0]  s1_mask;
  logic [3:0]            s1_len;

  coef_magnitude #(
    .W  (COEF_WIDTH),
    .IW (LOG2_N),
    .MW (MASK_BITS)
  ) u_coef_magnitude (
    .clk      (clk),
    .rst      (rst),
    .in_valid (coef_valid),
    .coef     (coef),
    .idx      (coef_idx_reg),
    .mask     (mask_idx_reg),
    .first    (first),
    .eoc      (eoc),
    .err      (beat_err),
    .len      (len_cur),
    .s1_valid (s1_valid),
    .s1_mag   (s1_mag),
    .s1_sign  (s1_sign),
    .s1_idx   (s1_idx),
    .s1_mask  (s1_mask),
    .s1_first (s1_first),
    .s1_eoc   (s1_eoc),
    .s1_err   (s1_err),
    .s1_len   (s1_len)
  );

  dec_word_t             best_reg, best_next;
  logic [COEF_WIDTH-1:0] best_mag_reg, best_mag_next;
  logic                  err_acc_reg, err_next, take;

  // Strict greater-than keeps the earliest beat on ties.
  always_comb begin
    take          = s1_valid && (s1_first || (s1_mag > best_mag_reg));
    best_next     = best_reg;
    best_mag_next = best_mag_reg;
    if (take) begin
      best_next     = '{mask: s1_mask, idx: s1_idx, sign: s1_sign};
      best_mag_next = s1_mag;
    end
    err_next = s1_first ? s1_err : (err_acc_reg | s1_err);
  end

  logic [DEC_WIDTH-1:0]  dec_bits_reg;
  logic [COEF_WIDTH-1:0] best_metric_reg;
  logic                  dec_valid_reg, frame_err_reg;

  // Best tracking, sticky error and output registers; the result is formed
  // from the next-state values so the end beat itself can win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_reg        <= '0;
      best_mag_reg    <= '0;
      err_acc_reg     <= 1'b0;
      dec_bits_reg    <= '0;
      best_metric_reg <= '0;
      dec_valid_reg   <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      dec_valid_reg <= 1'b0;
      if (s1_valid) begin
        best_reg     <= best_next;
        best_mag_reg <= best_mag_next;
        err_acc_reg  <= err_next;
        if (s1_eoc) begin
          dec_bits_reg    <= mask_to_length(best_next, s1_len);
          best_metric_reg <= best_mag_next;
          frame_err_reg   <= err_next;
          dec_valid_reg   <= 1'b1;
        end
      end
    end
  end

  assign dec_bits    = dec_bits_reg;
  assign best_metric = best_metric_reg;
  assign dec_valid   = dec_valid_reg;
  assign frame_err   = frame_err_reg;

endmodule

// File: tb/tb_fht_max_search.sv
// Scoreboard bench for fht_max_search: directed codewords push their
// hand-computed decision; a negedge monitor pops and compares on dec_valid.
module tb_fht_max_search;

  logic               clk;
  logic               rst;
  logic signed [9:0]  coef;
  logic               coef_valid, coef_last, mask_last;
  logic [3:0]         code_length;
  logic [12:0]        dec_bits;
  logic [9:0]         best_metric;
  logic               dec_valid, frame_err;

  fht_max_search dut (
    .clk         (clk),
    .rst         (rst),
    .coef        (coef),
    .coef_valid  (coef_valid),
    .coef_last   (coef_last),
    .mask_last   (mask_last),
    .code_length (code_length),
    .dec_bits    (dec_bits),
    .best_metric (best_metric),
    .dec_valid   (dec_valid),
    .frame_err   (frame_err)
  );

  typedef struct {
    logic [12:0] bits;
    logic [9:0]  metric;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t              sb[$];
  logic [12:0]       exp_bits;
  logic [9:0]        exp_metric;
  logic              exp_err;
  logic signed [9:0] frame_buf[32];
  int                cyc = 0;
  int                n_vec = 0;
  int                n_bad = 0;
  logic              prev_dv = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every dec_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dec_valid) begin
      if (prev_dv) chk("dec_valid_width", 2, 1);
      if (sb.size() == 0) begin
        chk("unexpected_dec_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dec_bits", int'(dec_bits), int'(e.bits));
        chk("best_metric", int'(best_metric), int'(e.metric));
        chk("frame_err", int'(frame_err), int'(e.err));
        chk("latency_cycle", cyc, e.cyc);
        $display("result: dec_bits=0x%03h metric=%0d err=%0d at cycle %0d",
                 dec_bits, best_metric, frame_err, cyc);
      end
    end
    prev_dv = dec_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      coef_valid = 1'b0;
      coef_last  = 1'b0;
      mask_last  = 1'b0;
    end
  endtask

  // Drive one beat; the end-of-codeword beat records its expected result.
  task automatic drive_beat(input logic signed [9:0] c, input logic cl,
                            input logic ml, input logic [3:0] len);
    exp_t e;
    @(negedge clk);
    coef        = c;
    coef_valid  = 1'b1;
    coef_last   = cl;
    mask_last   = ml;
    code_length = len;
    if (cl && ml) begin
      e.bits   = exp_bits;
      e.metric = exp_metric;
      e.err    = exp_err;
      e.cyc    = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int n, input logic ml, input logic [3:0] len,
                            input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
      drive_beat(frame_buf[i], i == n - 1, ml && (i == n - 1), len);
    end
  endtask

  task automatic clear_buf();
    for (int i = 0; i < 32; i++) frame_buf[i] = '0;
  endtask

  task automatic set_expect(input logic [12:0] b, input logic [9:0] m, input logic e);
    exp_bits   = b;
    exp_metric = m;
    exp_err    = e;
  endtask

  // Four-frame codeword with a tie at 300: mask 1 idx 5 vs mask 2 idx 1.
  task automatic tie_codeword(input logic [3:0] len0, input logic [3:0] len_rest);
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < 32; i++) frame_buf[i] = 10'(((i * 13 + m * 7) % 101) - 50);
      if (m == 1) frame_buf[5] = 10'sd300;
      if (m == 2) frame_buf[1] = 10'sd300;
      send_frame(32, m == 3, (m == 0) ? len0 : len_rest, 0);
    end
  endtask

  initial begin
    rst = 1'b1; coef = '0; coef_valid = 1'b0; coef_last = 1'b0;
    mask_last = 1'b0; code_length = 4'd13;
    set_expect('0, '0, 1'b0);
    #3 rst = 1'b0;
    idle(3);
    #1;
    chk("reset_dec_bits", int'(dec_bits), 0);
    chk("reset_best_metric", int'(best_metric), 0);
    chk("reset_dec_valid", int'(dec_valid), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // Single frame, +100 at index 9, A=6.
    clear_buf(); frame_buf[9] = 10'sd100;
    set_expect(13'h012, 10'd100, 1'b0);
    send_frame(32, 1'b1, 4'd6, 0);
    idle(4);

    // -512 at index 3 among values within +/-200, A=6.
    for (int i = 0; i < 32; i++) frame_buf[i] = 10'(((i * 37) % 401) - 200);
    frame_buf[3] = -10'sd512;
    set_expect(13'h007, 10'd512, 1'b0);
    send_frame(32, 1'b1, 4'd6, 0);
    idle(4);

    // Tie across masks, A=13 (later frames carry A=2, which must be ignored).
    set_expect(13'h04A, 10'd300, 1'b0);
    tie_codeword(4'd13, 4'd2);
    idle(4);

    // Same winner truncated to A=4.
    set_expect(13'h00A, 10'd300, 1'b0);
    tie_codeword(4'd4, 4'd13);
    idle(4);

    // Back-to-back codewords with random gaps; B starts right after A.
    for (int i = 0; i < 32; i++) frame_buf[i] = 10'(((i * 29) % 201) - 100);
    frame_buf[17] = 10'sd250;
    set_expect(13'h022, 10'd250, 1'b0);
    send_frame(32, 1'b1, 4'd13, 3);
    for (int i = 0; i < 32; i++) frame_buf[i] = 10'(((i * 11) % 301) - 150);
    set_expect(13'h07D, 10'd400, 1'b0);
    send_frame(32, 1'b0, 4'd7, 3);
    frame_buf[30] = -10'sd400;
    send_frame(32, 1'b1, 4'd9, 3);
    idle(4);

    // coef_last at index 20.
    clear_buf(); frame_buf[4] = -10'sd50;
    set_expect(13'h009, 10'd50, 1'b1);
    send_frame(21, 1'b1, 4'd13, 0);
    idle(4);

    // A=0 is treated as 13 and flags an error.
    clear_buf(); frame_buf[2] = 10'sd7;
    set_expect(13'h004, 10'd7, 1'b1);
    send_frame(32, 1'b1, 4'd0, 0);
    idle(4);

    // Reset mid-frame: outputs clear at once, partial codeword discarded.
    clear_buf(); frame_buf[6] = 10'sd99;
    for (int i = 0; i < 10; i++) drive_beat(frame_buf[i], 1'b0, 1'b0, 4'd13);
    @(negedge clk);
    rst = 1'b0; coef_valid = 1'b0;
    #1;
    chk("midreset_dec_bits", int'(dec_bits), 0);
    chk("midreset_best_metric", int'(best_metric), 0);
    chk("midreset_dec_valid", int'(dec_valid), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    idle(2);
    @(negedge clk) rst = 1'b1;
    idle(2);

    // Clean codeword after reset.
    clear_buf(); frame_buf[31] = -10'sd1;
    set_expect(13'h03F, 10'd1, 1'b0);
    send_frame(32, 1'b1, 4'd13, 0);

    // Drain, bounded.
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    idle(3);
    if (sb.size() != 0) chk("drain_timeout_pending", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
